// File: rtl/rr_arbiter_lock_pkg.sv
// Shared types and helpers for the rr_arbiter_lock round-robin arbiter.
package rr_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // One-hot vector with bit idx set; all-zero when idx lies outside 0..n-1.
    function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
        logic [MAX_REQ-1:0] vec;
        vec = '0;
        if ((idx >= 0) && (idx < n) && (idx < MAX_REQ)) begin
            vec = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
        end else begin
            vec = '0;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter_lock_if.sv
// Request/grant bundle between requesters (master) and rr_arbiter_lock (slave).
interface rr_arbiter_lock_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;

    modport master (output req, input grant, input grant_valid, input grant_idx);
    modport slave  (input req, output grant, output grant_valid, output grant_idx);
endinterface

// File: rtl/rr_arbiter_lock_prio_pick.sv
// Combinational rotating priority search: first set req bit at or after ptr, wrapping at NUM_REQ.
module rr_prio_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   off_s;
    logic [IDX_W:0]     sum_s;

    // Rotate req so bit 0 is requester ptr, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot_s = NUM_REQ'({req, req} >> ptr);
        found = 1'b0;
        off_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            found = found | rot_s[i];
            off_s = rot_s[i] ? IDX_W'(i) : off_s;
        end
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= NUM_W) begin
            idx = IDX_W'(sum_s - NUM_W);
        end else begin
            idx = sum_s[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/rr_arbiter_lock.sv
// N-way round-robin arbiter with grant locking until the owner drops req.
// Optional owner hold-time limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_lock
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_arbiter_lock_if.slave   bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic               valid_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   ptr_r;

    logic               keep_s;
    logic               revoke_s;
    logic               release_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [IDX_W-1:0]   pick_ptr_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [MAX_REQ-1:0] oh_s;
    logic [NUM_REQ-1:0] pick_oh_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_MAX = 16'(MAX_HOLD);
    logic [15:0] hold_r;
    logic        others_s;
`else
    logic unused_hold_s;
    assign unused_hold_s = (MAX_HOLD > 0);
`endif

    // Release (or revoke) decision and the pointer the picker searches from this edge.
    always_comb begin
        keep_s     = bus.req[idx_r];
        next_ptr_s = (idx_r == LAST_IDX) ? '0 : (idx_r + IDX_W'(1));
`ifdef ARB_TIMEOUT_EN
        others_s   = |(bus.req & ~grant_r);
        revoke_s   = (hold_r >= HOLD_MAX) && others_s;
`else
        revoke_s   = 1'b0;
`endif
        release_s  = (state_r == OWNED) && (!keep_s || revoke_s);
        pick_ptr_s = release_s ? next_ptr_s : ptr_r;
    end

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // One-hot form of the picked index.
    always_comb begin
        oh_s      = onehot(int'(pick_idx_s), NUM_REQ);
        pick_oh_s = oh_s[NUM_REQ-1:0];
    end

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= '0;
            valid_r <= 1'b0;
            idx_r   <= '0;
            ptr_r   <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_r  <= 16'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        grant_r <= pick_oh_s;
                        valid_r <= 1'b1;
                        idx_r   <= pick_idx_s;
                        state_r <= OWNED;
`ifdef ARB_TIMEOUT_EN
                        hold_r  <= 16'd1;
`endif
                    end else begin
                        grant_r <= '0;
                        valid_r <= 1'b0;
                    end
                end
                OWNED: begin
                    if (release_s) begin
                        ptr_r <= next_ptr_s;
                        if (pick_found_s) begin
                            grant_r <= pick_oh_s;
                            valid_r <= 1'b1;
                            idx_r   <= pick_idx_s;
`ifdef ARB_TIMEOUT_EN
                            hold_r  <= 16'd1;
`endif
                        end else begin
                            grant_r <= '0;
                            valid_r <= 1'b0;
                            state_r <= IDLE;
`ifdef ARB_TIMEOUT_EN
                            hold_r  <= 16'd0;
`endif
                        end
                    end else begin
                        state_r <= OWNED;
`ifdef ARB_TIMEOUT_EN
                        if (hold_r < HOLD_MAX) begin
                            hold_r <= hold_r + 16'd1;
                        end else begin
                            hold_r <= hold_r;
                        end
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_valid = valid_r;
    assign bus.grant_idx   = idx_r;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Scoreboard bench for rr_arbiter_lock: a 4-way and a 3-way instance share clock and reset.
module tb_rr_arbiter_lock;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 16;
`endif

    typedef struct {
        int         due;
        int         which;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    rr_arbiter_lock_if #(.NUM_REQ(4)) if4();
    rr_arbiter_lock_if #(.NUM_REQ(3)) if3();

    rr_arbiter_lock #(.NUM_REQ(4), .MAX_HOLD(HOLD)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    rr_arbiter_lock #(.NUM_REQ(3), .MAX_HOLD(HOLD)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // Apply one cycle of req to the chosen DUT and queue the output due after the next edge.
    task automatic step(input int which, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] i, input logic v);
        exp_t e;
        @(posedge clk);
        #1;
        if (which == 0) if4.req = r;
        else            if3.req = r[2:0];
        e.due = cyc + 1; e.which = which; e.grant = g; e.idx = i; e.valid = v;
        sb.push_back(e);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_grant4", int'(if4.grant), 0);
        chk("rst_valid4", int'(if4.grant_valid), 0);
        chk("rst_idx4", int'(if4.grant_idx), 0);
        chk("rst_grant3", int'(if3.grant), 0);
        if4.req = 4'b0000;
        if3.req = 3'b000;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pop expected outputs when due, plus per-cycle structural invariants.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("due_cycle", cyc, e.due);
            if (e.which == 0) begin
                chk("grant4", int'(if4.grant), int'(e.grant));
                chk("idx4", int'(if4.grant_idx), int'(e.idx));
                chk("valid4", int'(if4.grant_valid), int'(e.valid));
            end else begin
                chk("grant3", int'(if3.grant), int'(e.grant));
                chk("idx3", int'(if3.grant_idx), int'(e.idx));
                chk("valid3", int'(if3.grant_valid), int'(e.valid));
            end
        end
        if (mon_en) begin
            chk("onehot4", int'((if4.grant & (if4.grant - 4'd1)) == 4'd0), 1);
            chk("or_valid4", int'(if4.grant_valid), int'(|if4.grant));
            chk("onehot3", int'((if3.grant & (if3.grant - 3'd1)) == 3'd0), 1);
            chk("or_valid3", int'(if3.grant_valid), int'(|if3.grant));
            chk("idx3_range", int'(if3.grant_idx < 2'd3), 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        if4.req = 4'b0000;
        if3.req = 3'b000;
        #1;
        do_reset();

        // Single request: 1-cycle latency, then release to idle.
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0000, 4'b0000, 2'd2, 1'b0);
        do_reset();

        // All requesting; each owner drops req for one cycle after two granted cycles.
        step(0, 4'b1111, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b1111, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b1110, 4'b0010, 2'd1, 1'b1);
        step(0, 4'b1111, 4'b0010, 2'd1, 1'b1);
        step(0, 4'b1101, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b1111, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b1011, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b1111, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b0111, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Wrap from owner 3 to 0, then back to 3; rotating pointer beats fixed priority.
        step(0, 4'b1000, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b1001, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b0001, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b1001, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b1000, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b0000, 4'b0000, 2'd3, 1'b0);
        step(0, 4'b0110, 4'b0010, 2'd1, 1'b1);
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0011, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Reset while requester 1 owns the grant, then restart from requester 0.
        step(0, 4'b1111, 4'b0010, 2'd1, 1'b1);
        step(0, 4'b1111, 4'b0010, 2'd1, 1'b1);
        do_reset();
        step(0, 4'b1111, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b1111, 4'b0001, 2'd0, 1'b1);
        do_reset();

        // req0 held with req1 competing: revoked after HOLD cycles only with the timeout built.
        for (int k = 1; k <= 9; k++) begin
`ifdef ARB_TIMEOUT_EN
            if (k <= 4 || k == 9) step(0, 4'b0011, 4'b0001, 2'd0, 1'b1);
            else                  step(0, 4'b0011, 4'b0010, 2'd1, 1'b1);
`else
            step(0, 4'b0011, 4'b0001, 2'd0, 1'b1);
`endif
        end
        for (int k = 0; k < 105; k++) begin
            step(0, 4'b0001, 4'b0001, 2'd0, 1'b1);
        end
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Three requesters: wrap at index 2 to 0, never a phantom index 3.
        step(1, 4'b0100, 4'b0100, 2'd2, 1'b1);
        step(1, 4'b0110, 4'b0100, 2'd2, 1'b1);
        step(1, 4'b0011, 4'b0001, 2'd0, 1'b1);
        step(1, 4'b0010, 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0100, 4'b0100, 2'd2, 1'b1);
        step(1, 4'b0001, 4'b0001, 2'd0, 1'b1);
        step(1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1, 4'b0101, 4'b0100, 2'd2, 1'b1);
        step(1, 4'b0001, 4'b0001, 2'd0, 1'b1);
        step(1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
